// File: rtl/tile_renderer_pkg.sv
// tile_pkg: shared constants and types for the tile renderer.
//   - grid geometry (6 x 8 tiles of 40 px, 4 px cursor border)
//   - palette codes for tile values 4..7 and the cursor code
//   - tile_code_t, plus a palette lookup helper
package tile_pkg;

  localparam int GRID_COLS = 6;
  localparam int GRID_ROWS = 8;
  localparam int NUM_TILES = GRID_COLS * GRID_ROWS;
  localparam int TILE_SIZE = 40;
  localparam int BORDER    = 4;

  localparam logic [12:0] PAL_4       = 13'h174F;
  localparam logic [12:0] PAL_5       = 13'h1F46;
  localparam logic [12:0] PAL_6       = 13'h1F4F;
  localparam logic [12:0] PAL_7       = 13'h14FF;
  localparam logic [12:0] CURSOR_CODE = 13'h1FF4;

  typedef logic [2:0] tile_code_t;

  // Codes 0..3 are background and render as black.
  function automatic logic [12:0] palette(input tile_code_t code);
    logic [12:0] p;
    case (code)
      3'd4:    p = PAL_4;
      3'd5:    p = PAL_5;
      3'd6:    p = PAL_6;
      3'd7:    p = PAL_7;
      default: p = 13'h0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// tile_renderer_if: snooped data-RAM write bus.
//   wr_en   - write strobe
//   wr_addr - 12-bit word address
//   wr_data - 32-bit write data
// master drives the bus (CPU side / bench), slave observes it (renderer).
interface tile_renderer_if;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tile_renderer_axis.sv
// tile_axis: combinational coordinate-to-tile mapping along one axis.
//   coord_i    - pixel coordinate on this axis
//   idx_o      - tile index, (coord - ORIGIN) / TILE_SIZE
//   off_o      - offset inside the tile, (coord - ORIGIN) mod TILE_SIZE
//   in_range_o - ORIGIN <= coord < ORIGIN + COUNT*TILE_SIZE
// idx_o/off_o are meaningless when in_range_o is low.
module tile_axis
  import tile_pkg::*;
#(
  parameter int W      = 10,
  parameter int ORIGIN = 200,
  parameter int COUNT  = 6
) (
  input  logic [W-1:0] coord_i,
  output logic [2:0]   idx_o,
  output logic [5:0]   off_o,
  output logic         in_range_o
);

  logic [W-1:0] rel;

  // Compare ladder instead of a divider: the last threshold k*TILE_SIZE
  // not exceeding rel gives the index, and rel minus it gives the offset.
  always_comb begin
    rel        = coord_i - W'(ORIGIN);
    in_range_o = (coord_i >= W'(ORIGIN)) && (rel < W'(COUNT * TILE_SIZE));
    idx_o      = 3'd0;
    off_o      = 6'(rel);
    for (int k = 1; k < COUNT; k++) begin
      if (rel >= W'(k * TILE_SIZE)) begin
        idx_o = 3'(k);
        off_o = 6'(rel - W'(k * TILE_SIZE));
      end
    end
  end

endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: snoops CPU data-RAM writes to build a double-buffered
// 6x8 tile map and cursor, and renders a 13-bit pixel code per VGA
// coordinate with a 2-cycle pipeline.
//   clk, rst     - clock, synchronous active-high reset
//   bus          - snooped write bus (slave modport)
//   frame_start  - commits back buffer + back cursor to the front
//   row, col     - VGA coordinate being presented
//   pixel        - pixel code for the coordinate presented 2 clk earlier
//   score        - last word written to SCORE_ADDR (unbuffered)
//   cur_row/col  - displayed (front) cursor position
module tile_renderer
  import tile_pkg::*;
#(
  parameter int          TILE_BASE  = 500,
  parameter int          CURR_ADDR  = 498,
  parameter int          CURC_ADDR  = 497,
  parameter logic [11:0] SCORE_ADDR = 12'hCFF,
  parameter int          X0         = 200,
  parameter int          Y0         = 80
) (
  input  logic                clk,
  input  logic                rst,
  tile_renderer_if.slave      bus,
  input  logic                frame_start,
  input  logic [8:0]          row,
  input  logic [9:0]          col,
  output logic [12:0]         pixel,
  output logic [31:0]         score,
  output logic [2:0]          cur_row,
  output logic [2:0]          cur_col
);

  // ---------------- buffers ----------------
  tile_code_t back_q  [NUM_TILES];
  tile_code_t front_q [NUM_TILES];
  tile_code_t back_cur_row_q, back_cur_col_q;
  tile_code_t front_cur_row_q, front_cur_col_q;
  logic [31:0] score_q;

  logic [NUM_TILES-1:0] tile_hit;
  logic                 curr_hit, curc_hit, score_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TILES; gi++) begin : g_hit
      assign tile_hit[gi] = bus.wr_en && (bus.wr_addr == 12'(TILE_BASE + gi));
    end
  endgenerate

  assign curr_hit  = bus.wr_en && (bus.wr_addr == 12'(CURR_ADDR));
  assign curc_hit  = bus.wr_en && (bus.wr_addr == 12'(CURC_ADDR));
  assign score_hit = bus.wr_en && (bus.wr_addr == SCORE_ADDR);

  // The commit copies the registered back contents, so a write in the same
  // cycle as frame_start only reaches the back buffer and waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
      back_cur_row_q  <= '0;
      back_cur_col_q  <= '0;
      front_cur_row_q <= '0;
      front_cur_col_q <= '0;
      score_q         <= '0;
    end else begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (tile_hit[i])  back_q[i]  <= bus.wr_data[2:0];
        if (frame_start)  front_q[i] <= back_q[i];
      end
      if (curr_hit)  back_cur_row_q <= bus.wr_data[2:0];
      if (curc_hit)  back_cur_col_q <= bus.wr_data[2:0];
      if (frame_start) begin
        front_cur_row_q <= back_cur_row_q;
        front_cur_col_q <= back_cur_col_q;
      end
      if (score_hit) score_q <= bus.wr_data;
    end
  end

  // ---------------- stage 1: coordinate mapping ----------------
  logic [2:0] tc_d, tr_d;
  logic [5:0] oc_d, or_d;
  logic       col_in, row_in;

  tile_axis #(.W(10), .ORIGIN(X0), .COUNT(GRID_COLS)) u_col_axis (
    .coord_i    (col),
    .idx_o      (tc_d),
    .off_o      (oc_d),
    .in_range_o (col_in)
  );

  tile_axis #(.W(9), .ORIGIN(Y0), .COUNT(GRID_ROWS)) u_row_axis (
    .coord_i    (row),
    .idx_o      (tr_d),
    .off_o      (or_d),
    .in_range_o (row_in)
  );

  logic       in_grid_q;
  logic [2:0] tc_q, tr_q;
  logic [5:0] oc_q, or_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_grid_q <= 1'b0;
      tc_q      <= '0;
      tr_q      <= '0;
      oc_q      <= '0;
      or_q      <= '0;
    end else begin
      in_grid_q <= col_in && row_in;
      tc_q      <= tc_d;
      tr_q      <= tr_d;
      oc_q      <= oc_d;
      or_q      <= or_d;
    end
  end

  // ---------------- stage 2: cursor / palette ----------------
  logic [5:0]  tile_idx;
  tile_code_t  tile_code;
  logic        on_border, cursor_hit;
  logic [12:0] pixel_d, pixel_q;

  always_comb begin
    // tr*6 + tc without a multiplier
    tile_idx   = {1'b0, tr_q, 2'b00} + {2'b00, tr_q, 1'b0} + {3'b000, tc_q};
    tile_code  = (tile_idx < 6'(NUM_TILES)) ? front_q[tile_idx] : '0;
    on_border  = (oc_q < 6'(BORDER)) || (oc_q >= 6'(TILE_SIZE - BORDER)) ||
                 (or_q < 6'(BORDER)) || (or_q >= 6'(TILE_SIZE - BORDER));
    // Out-of-range cursor values can never equal a valid tr/tc.
    cursor_hit = in_grid_q && (tr_q == front_cur_row_q) &&
                 (tc_q == front_cur_col_q) && on_border;
    if (cursor_hit)     pixel_d = CURSOR_CODE;
    else if (in_grid_q) pixel_d = palette(tile_code);
    else                pixel_d = 13'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) pixel_q <= '0;
    else     pixel_q <= pixel_d;
  end

  assign pixel   = pixel_q;
  assign score   = score_q;
  assign cur_row = front_cur_row_q;
  assign cur_col = front_cur_col_q;

endmodule
